uart_tx_buffered: RTL and testbench

//  Parametrised, FIFO-buffered UART transmitter with an internal baud generator, configurable frame format and a valid/ready write port.

---
 rtl/uart_tx_buffered_pkg.sv | 28 ++
 rtl/uart_tx_buffered_if.sv | 11 +
 rtl/uart_tx_buffered_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter (and the future rx path):
// parity codes, FSM state encoding and frame-length helper.
package uart_tx_buffered_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SUB_W      = 4;
  localparam int unsigned BIT_CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready byte write port of the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level counter; a push is refused
// whenever the FIFO is full, even if a pop happens on the same cycle.
module uart_tx_buffered_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: 16x baud divider, configurable data/parity/stop
// format, back-to-back frames with no idle gap while the FIFO holds data.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_buffered_if.slave           wr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e              state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [SUB_W-1:0]       sub_q, sub_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_d;

  logic                   tick;
  logic                   bit_end;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rd_data;

  uart_tx_buffered_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr.wr_valid),
    .pop     (fifo_pop),
    .wr_data (wr.wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wr.wr_ready = ~fifo_full;
  assign busy        = (state_q != ST_IDLE) | (fifo_level != '0);

  assign tick    = (tick_q == TICK_W'(CLK_DIV - 1));
  assign bit_end = tick & (sub_q == SUB_W'(OVERSAMPLE - 1));

  // Next-state, counters, shift/parity datapath and line level.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    sub_d    = sub_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;

    if (state_q != ST_IDLE) begin
      tick_d = tick ? '0 : tick_q + TICK_W'(1);
      if (tick) begin
        sub_d = sub_q + SUB_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        tick_d = '0;
        sub_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          par_d    = 1'(PARITY == PARITY_ODD);
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rd_data;
              par_d    = 1'(PARITY == PARITY_ODD);
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      sub_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (8N1, 7E2, 7O2) checked every cycle
// against a frame-timing model, plus directed literal expectations.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int unsigned NDUT    = 3;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BP      = 16 * CLK_DIV;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned P_DB  [NDUT] = '{8, 7, 7};
  localparam int unsigned P_PAR [NDUT] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD};
  localparam int unsigned P_SB  [NDUT] = '{1, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  int checks = 0;
  int errors = 0;

  logic [NDUT-1:0][7:0] drv_data;
  logic [NDUT-1:0]      drv_valid;
  logic [NDUT-1:0]      drv_reset;
  logic [NDUT-1:0]      tx_w;
  logic [NDUT-1:0]      busy_w;
  logic [NDUT-1:0]      ready_w;
  logic [NDUT-1:0][2:0] level_w;

  task automatic check(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, k, cyc_g, act, exp);
    end
  endtask

  // Expected line pattern of one frame, LSB first; unused upper positions stay 1.
  function automatic logic [15:0] frame_vec(input int unsigned db, input int unsigned par,
                                            input logic [7:0] d);
    logic [15:0] v;
    int ones;
    v    = '1;
    ones = 0;
    v[0] = 1'b0;
    for (int i = 0; i < int'(db); i++) begin
      v[i+1] = d[i];
      ones   = ones + int'(d[i]);
    end
    if (par == PARITY_EVEN) v[db+1] = 1'((ones % 2) == 1);
    else if (par == PARITY_ODD) v[db+1] = 1'((ones % 2) == 0);
    return v;
  endfunction

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int unsigned DB  = P_DB[k];
    localparam int unsigned PAR = P_PAR[k];
    localparam int unsigned SB  = P_SB[k];
    localparam int unsigned FB  = frame_bits(DB, PAR, SB);

    uart_tx_buffered_if #(.DATA_BITS(DB)) wr_if ();
    logic       tx;
    logic       busy;
    logic [2:0] level;

    assign wr_if.wr_data  = drv_data[k][DB-1:0];
    assign wr_if.wr_valid = drv_valid[k];
    assign tx_w[k]        = tx;
    assign busy_w[k]      = busy;
    assign ready_w[k]     = wr_if.wr_ready;
    assign level_w[k]     = level;

    uart_tx_buffered #(
      .CLK_DIV    (CLK_DIV),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk        (clk),
      .reset      (drv_reset[k]),
      .wr         (wr_if),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (level)
    );

    // Model: a byte accepted at edge a starts its frame after edge max(a+2, end of previous frame).
    logic [7:0]  mq_data [$];
    longint      mq_acc  [$];
    longint      m_cyc      = 0;
    longint      cur_start  = 0;
    longint      end_at     = 0;
    logic        have_frame = 1'b0;
    logic [15:0] cur_bits   = '1;
    logic        e_tx = 1'b1, e_busy = 1'b0, e_ready = 1'b1, m_live = 1'b0;
    int          e_level = 0;

    always @(posedge clk) begin
      logic take;
      m_cyc  = m_cyc + 1;
      m_live = 1'b1;
      if (drv_reset[k]) begin
        mq_data.delete();
        mq_acc.delete();
        have_frame = 1'b0;
        end_at     = 0;
      end else begin
        take = drv_valid[k] && (mq_data.size() < int'(DEPTH));
        if (mq_data.size() != 0 && m_cyc >= mq_acc[0] + 1 && m_cyc + 1 >= end_at) begin
          cur_start  = m_cyc + 1;
          cur_bits   = frame_vec(DB, PAR, mq_data[0]);
          end_at     = cur_start + longint'(FB * BP);
          have_frame = 1'b1;
          void'(mq_data.pop_front());
          void'(mq_acc.pop_front());
        end
        if (take) begin
          mq_data.push_back(drv_data[k]);
          mq_acc.push_back(m_cyc);
        end
      end
      if (have_frame && m_cyc >= cur_start && m_cyc < end_at)
        e_tx = cur_bits[int'((m_cyc - cur_start) / longint'(BP))];
      else
        e_tx = 1'b1;
      e_busy  = (mq_data.size() != 0) || (have_frame && (m_cyc + 1 < end_at));
      e_level = mq_data.size();
      e_ready = (mq_data.size() != int'(DEPTH));
    end

    always @(negedge clk) begin
      if (m_live) begin
        check("tx", k, longint'(tx), longint'(e_tx));
        check("busy", k, longint'(busy), longint'(e_busy));
        check("fifo_level", k, longint'(level), longint'(e_level));
        check("wr_ready", k, longint'(wr_if.wr_ready), longint'(e_ready));
      end
    end
  end

  task automatic goto(input longint c);
    while (cyc_g < c) @(negedge clk);
  endtask

  // Called at a negedge; the push is sampled at the next posedge, returned as edge_n.
  task automatic push1(input int k, input logic [7:0] d, output longint edge_n);
    drv_data[k]  = d;
    drv_valid[k] = 1'b1;
    edge_n       = cyc_g + 1;
    @(negedge clk);
    drv_valid[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    longint     n, s, e, n2;
    logic [9:0] t1_seq;
    int         d, budget, max_lvl;
    logic       acc_next, seen_low;

    t1_seq    = 10'b1101001010;
    drv_reset = '1;
    drv_valid = '0;
    drv_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 0, longint'(tx_w[0]), 1);
    check("rst_busy", 0, longint'(busy_w[0]), 0);
    check("rst_level", 0, longint'(level_w[0]), 0);
    check("rst_ready", 0, longint'(ready_w[0]), 1);
    drv_reset = '0;
    repeat (2) @(negedge clk);

    // 8N1 frame of 8'hA5
    push1(0, 8'hA5, n);
    goto(n + 1);
    check("t1_pre_fall", 0, longint'(tx_w[0]), 1);
    goto(n + 2);
    check("t1_fall", 0, longint'(tx_w[0]), 0);
    for (int b = 0; b < 10; b++) begin
      goto(n + 2 + longint'(b * BP + BP / 2));
      check("t1_bit", 0, longint'(tx_w[0]), longint'(t1_seq[b]));
    end
    goto(n + 2 + longint'(10 * BP));
    check("t1_busy_end", 0, longint'(busy_w[0]), 0);
    check("t1_level_end", 0, longint'(level_w[0]), 0);
    repeat (20) @(negedge clk);

    // Back-to-back frames
    drv_data[0] = 8'h55; drv_valid[0] = 1'b1; n = cyc_g + 1;
    @(negedge clk); drv_data[0] = 8'h0F;
    check("t2_idle", 0, longint'(tx_w[0]), 1);
    @(negedge clk); drv_data[0] = 8'hFF;
    check("t2_pre_fall", 0, longint'(tx_w[0]), 1);
    @(negedge clk); drv_valid[0] = 1'b0;
    check("t2_fall", 0, longint'(tx_w[0]), 0);
    goto(n + 1 + longint'(10 * BP));
    check("t2_stop1", 0, longint'(tx_w[0]), 1);
    goto(n + 2 + longint'(10 * BP));
    check("t2_start2", 0, longint'(tx_w[0]), 0);
    goto(n + 2 + longint'(20 * BP));
    check("t2_start3", 0, longint'(tx_w[0]), 0);
    goto(n + longint'(30 * BP));
    check("t2_busy_last", 0, longint'(busy_w[0]), 1);
    goto(n + 1 + longint'(30 * BP));
    check("t2_busy_done", 0, longint'(busy_w[0]), 0);
    check("t2_last_stop", 0, longint'(tx_w[0]), 1);
    repeat (10) @(negedge clk);

    // Full FIFO with continuous valid
    d = 0; seen_low = 1'b0; max_lvl = 0; budget = 20000;
    drv_valid[0] = 1'b1;
    while (d < 8 && budget > 0) begin
      drv_data[0] = 8'(d);
      acc_next    = ready_w[0];
      @(negedge clk);
      budget--;
      if (acc_next) d++;
      if (!ready_w[0]) seen_low = 1'b1;
      if (int'(level_w[0]) > max_lvl) max_lvl = int'(level_w[0]);
    end
    drv_valid[0] = 1'b0;
    while (busy_w[0] && budget > 0) begin
      @(negedge clk);
      budget--;
      if (int'(level_w[0]) > max_lvl) max_lvl = int'(level_w[0]);
    end
    check("t3_all_pushed", 0, longint'(d), 8);
    check("t3_ready_dropped", 0, longint'(seen_low), 1);
    check("t3_max_level", 0, longint'(max_lvl), 4);
    check("t3_drained", 0, longint'(busy_w[0]), 0);
    repeat (10) @(negedge clk);

    // Frame formats: 7E2 and 7O2 with 7'h13
    drv_data[1] = 8'h13; drv_data[2] = 8'h13;
    drv_valid[1] = 1'b1; drv_valid[2] = 1'b1; n = cyc_g + 1;
    @(negedge clk);
    drv_valid[1] = 1'b0; drv_valid[2] = 1'b0;
    s = n + 2;
    goto(s + longint'(BP / 2));
    check("t4_start_e", 1, longint'(tx_w[1]), 0);
    goto(s + longint'(BP + BP / 2));
    check("t4_d0_e", 1, longint'(tx_w[1]), 1);
    goto(s + longint'(3 * BP + BP / 2));
    check("t4_d2_o", 2, longint'(tx_w[2]), 0);
    goto(s + longint'(8 * BP + BP / 2));
    check("t4_parity_even", 1, longint'(tx_w[1]), 1);
    check("t4_parity_odd", 2, longint'(tx_w[2]), 0);
    goto(s + longint'(9 * BP + BP / 2));
    check("t4_stop1", 1, longint'(tx_w[1]), 1);
    goto(s + longint'(10 * BP + BP / 2));
    check("t4_stop2", 2, longint'(tx_w[2]), 1);
    goto(s + longint'(11 * BP) - 2);
    check("t4_busy_in", 1, longint'(busy_w[1]), 1);
    goto(s + longint'(11 * BP) - 1);
    check("t4_busy_out_e", 1, longint'(busy_w[1]), 0);
    check("t4_busy_out_o", 2, longint'(busy_w[2]), 0);
    repeat (10) @(negedge clk);

    // Reset during the third data bit with two bytes queued
    drv_data[0] = 8'h3C; drv_valid[0] = 1'b1; n = cyc_g + 1;
    @(negedge clk); drv_data[0] = 8'h11;
    @(negedge clk); drv_data[0] = 8'h22;
    @(negedge clk); drv_valid[0] = 1'b0;
    s = n + 2;
    goto(s + longint'(3 * BP) + 10);
    check("t5_queued", 0, longint'(level_w[0]), 2);
    drv_reset[0] = 1'b1;
    @(negedge clk);
    drv_reset[0] = 1'b0;
    check("t5_tx", 0, longint'(tx_w[0]), 1);
    check("t5_level", 0, longint'(level_w[0]), 0);
    check("t5_busy", 0, longint'(busy_w[0]), 0);
    goto(cyc_g + longint'(12 * BP));
    check("t5_quiet", 0, longint'(tx_w[0]), 1);
    push1(0, 8'h81, n2);
    goto(n2 + 2);
    check("t5_fresh_fall", 0, longint'(tx_w[0]), 0);
    goto(n2 + 2 + longint'(BP + BP / 2));
    check("t5_fresh_d0", 0, longint'(tx_w[0]), 1);
    goto(n2 + 2 + longint'(2 * BP + BP / 2));
    check("t5_fresh_d1", 0, longint'(tx_w[0]), 0);
    goto(n2 + 2 + longint'(10 * BP));
    check("t5_fresh_done", 0, longint'(busy_w[0]), 0);
    repeat (10) @(negedge clk);

    // Push on the exact cycle the only queued entry is popped at stop end
    push1(0, 8'h5A, n);
    goto(n + 10);
    push1(0, 8'hC3, s);
    e = n + 1 + longint'(10 * BP);
    goto(e - 1);
    check("t6_before", 0, longint'(level_w[0]), 1);
    push1(0, 8'h96, n2);
    check("t6_push_edge", 0, n2, e);
    check("t6_level", 0, longint'(level_w[0]), 1);
    check("t6_busy", 0, longint'(busy_w[0]), 1);
    goto(e + 1);
    check("t6_next_start", 0, longint'(tx_w[0]), 0);
    goto(e + 1 + longint'(10 * BP));
    check("t6_third_start", 0, longint'(tx_w[0]), 0);
    goto(e + 1 + longint'(20 * BP));
    check("t6_done", 0, longint'(busy_w[0]), 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
